// File: rtl/boid_update_engine_if.sv
// Self, neighbour and result handshake channels between the boid memory sequencer
// (master) and the boid update engine (slave).

interface boid_update_engine_if #(
    parameter int W = 32
);
    logic                self_valid;
    logic                self_ready;
    logic                self_nonbr;
    logic signed [W-1:0] self_x;
    logic signed [W-1:0] self_y;
    logic signed [W-1:0] self_vx;
    logic signed [W-1:0] self_vy;

    logic                nbr_valid;
    logic                nbr_ready;
    logic                nbr_last;
    logic signed [W-1:0] nbr_x;
    logic signed [W-1:0] nbr_y;
    logic signed [W-1:0] nbr_vx;
    logic signed [W-1:0] nbr_vy;

    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_x;
    logic signed [W-1:0] out_y;
    logic signed [W-1:0] out_vx;
    logic signed [W-1:0] out_vy;

    modport master (
        output self_valid, self_nonbr, self_x, self_y, self_vx, self_vy,
        output nbr_valid, nbr_last, nbr_x, nbr_y, nbr_vx, nbr_vy,
        output out_ready,
        input  self_ready, nbr_ready, out_valid, out_x, out_y, out_vx, out_vy
    );

    modport slave (
        input  self_valid, self_nonbr, self_x, self_y, self_vx, self_vy,
        input  nbr_valid, nbr_last, nbr_x, nbr_y, nbr_vx, nbr_vy,
        input  out_ready,
        output self_ready, nbr_ready, out_valid, out_x, out_y, out_vx, out_vy
    );
endinterface

// File: rtl/boid_update_engine.sv
// Streaming boid update: accumulate neighbours, serial reciprocal, apply flocking rules.
// Optional speed limiting is compiled in when BOID_SPEED_LIMIT_EN is defined.

module boid_update_engine #(
    parameter int                  W          = 32,
    parameter int                  FRAC       = 16,
    parameter int                  MAX_NBR    = 63,
    parameter logic signed [W-1:0] VISUAL_SQ  = 1600 << FRAC,
    parameter logic signed [W-1:0] PROTECT_SQ = 64 << FRAC,
    parameter logic signed [W-1:0] X_MAX      = 640 << FRAC,
    parameter logic signed [W-1:0] Y_MAX      = 480 << FRAC,
    parameter logic signed [W-1:0] MARGIN     = 100 << FRAC,
    parameter logic signed [W-1:0] TURN       = 'h3999,
    parameter logic signed [W-1:0] AVOID      = 'h0666,
    parameter logic signed [W-1:0] MATCH      = 'h0666,
    parameter logic signed [W-1:0] CENTER     = 'h0010
`ifdef BOID_SPEED_LIMIT_EN
    ,
    parameter logic signed [W-1:0] MIN_SPEED  = 4 << FRAC,
    parameter logic signed [W-1:0] MAX_SPEED  = 8 << FRAC
`endif
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cfg_center_en,
    input  logic                         cfg_match_en,
    boid_update_engine_if.slave          bus,
    output logic [$clog2(MAX_NBR+1)-1:0] nbr_count,
    output logic                         busy
);

    localparam int CW = $clog2(MAX_NBR + 1);
    localparam int IW = $clog2(FRAC + 1);
    localparam logic [CW-1:0]       MAX_CNT   = CW'(MAX_NBR);
    localparam logic [IW-1:0]       DIV_START = IW'(FRAC);
    localparam logic signed [2*W:0] PROT_WIDE = {{(W+1){PROTECT_SQ[W-1]}}, PROTECT_SQ};
    localparam logic signed [2*W:0] VIS_WIDE  = {{(W+1){VISUAL_SQ[W-1]}}, VISUAL_SQ};

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DIV, S_APPLY, S_DONE} state_t;

    state_t r_state, w_nextState;

    logic signed [W-1:0] r_selfX, r_selfY, r_selfVx, r_selfVy;
    logic signed [W-1:0] r_sumX, r_sumY, r_sumVx, r_sumVy;
    logic signed [W-1:0] r_closeX, r_closeY;
    logic signed [W-1:0] r_outX, r_outY, r_outVx, r_outVy;
    logic [CW-1:0]       r_count;
    logic [CW:0]         r_rem;
    logic [W-1:0]        r_quo;
    logic [IW-1:0]       r_divIdx;

    logic w_selfReady, w_nbrReady, w_outValid;

    logic signed [W-1:0] w_dx, w_dy;
    logic signed [2*W:0] w_dxE, w_dyE, w_dsq;
    logic [CW+1:0]       w_remShift, w_remSub;
    logic                w_remGe;

    logic signed [W-1:0] w_avgX, w_avgY, w_avgVx, w_avgVy;
    logic signed [W-1:0] w_centerK, w_matchK;
    logic signed [W-1:0] w_vtX, w_vtY, w_vbX, w_vbY, w_vfX, w_vfY;
`ifdef BOID_SPEED_LIMIT_EN
    logic signed [W-1:0] w_absX, w_absY, w_spdMax, w_spdMin, w_speed;
`endif

    function automatic logic signed [W-1:0] fmul(input logic signed [W-1:0] a,
                                                 input logic signed [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
        return W'(p >>> FRAC);
    endfunction

    // State register; an asserted reset abandons any boid in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and handshake strobes; readies depend only on state, never on valids.
    always_comb begin
        w_nextState = r_state;
        w_selfReady = 1'b0;
        w_nbrReady  = 1'b0;
        w_outValid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_selfReady = 1'b1;
                if (bus.self_valid) begin
                    w_nextState = bus.self_nonbr ? S_DIV : S_ACCUM;
                end
            end
            S_ACCUM: begin
                w_nbrReady = 1'b1;
                if (bus.nbr_valid && bus.nbr_last) begin
                    w_nextState = S_DIV;
                end
            end
            S_DIV: begin
                if (r_count == '0 || r_divIdx == '0) begin
                    w_nextState = S_APPLY;
                end
            end
            S_APPLY: w_nextState = S_DONE;
            S_DONE: begin
                w_outValid = 1'b1;
                if (bus.out_ready) begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Squared distance keeps the full product width so large offsets never alias inside a radius.
    always_comb begin
        w_dx  = r_selfX - bus.nbr_x;
        w_dy  = r_selfY - bus.nbr_y;
        w_dxE = {{(W+1){w_dx[W-1]}}, w_dx};
        w_dyE = {{(W+1){w_dy[W-1]}}, w_dy};
        w_dsq = (w_dxE * w_dxE + w_dyE * w_dyE) >>> FRAC;
    end

    // One restoring step: the dividend 2^FRAC contributes a single 1 on the first step.
    always_comb begin
        w_remShift = {r_rem, (r_divIdx == DIV_START)};
        w_remSub   = w_remShift - {2'b00, r_count};
        w_remGe    = ~w_remSub[CW+1];
    end

    // Velocity update from the averaged neighbourhood, separation, margins and speed band.
    always_comb begin
        w_avgX    = fmul(r_sumX,  r_quo);
        w_avgY    = fmul(r_sumY,  r_quo);
        w_avgVx   = fmul(r_sumVx, r_quo);
        w_avgVy   = fmul(r_sumVy, r_quo);
        w_centerK = cfg_center_en ? CENTER : '0;
        w_matchK  = cfg_match_en  ? MATCH  : '0;

        w_vtX = r_selfVx + fmul(w_avgX - r_selfX, w_centerK)
              + fmul(w_avgVx - r_selfVx, w_matchK) + fmul(r_closeX, AVOID);
        w_vtY = r_selfVy + fmul(w_avgY - r_selfY, w_centerK)
              + fmul(w_avgVy - r_selfVy, w_matchK) + fmul(r_closeY, AVOID);

        w_vbX = w_vtX;
        if (r_selfX < MARGIN)               w_vbX = w_vtX + TURN;
        else if (r_selfX > X_MAX - MARGIN)  w_vbX = w_vtX - TURN;
        w_vbY = w_vtY;
        if (r_selfY < MARGIN)               w_vbY = w_vtY + TURN;
        else if (r_selfY > Y_MAX - MARGIN)  w_vbY = w_vtY - TURN;

`ifdef BOID_SPEED_LIMIT_EN
        w_absX   = w_vbX[W-1] ? -w_vbX : w_vbX;
        w_absY   = w_vbY[W-1] ? -w_vbY : w_vbY;
        w_spdMax = (w_absX > w_absY) ? w_absX : w_absY;
        w_spdMin = (w_absX > w_absY) ? w_absY : w_absX;
        w_speed  = w_spdMax + (w_spdMin >>> 1);
        w_vfX    = w_vbX;
        w_vfY    = w_vbY;
        if (w_speed > MAX_SPEED) begin
            w_vfX = w_vbX - (w_vbX >>> 2);
            w_vfY = w_vbY - (w_vbY >>> 2);
        end else if (w_speed < MIN_SPEED) begin
            w_vfX = w_vbX + (w_vbX >>> 2) + W'(1);
            w_vfY = w_vbY + (w_vbY >>> 2) + W'(1);
        end
`else
        w_vfX = w_vbX;
        w_vfY = w_vbY;
`endif
    end

    // Datapath registers: latch self, accumulate, divide, then register the result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_selfX  <= '0;  r_selfY  <= '0;  r_selfVx <= '0;  r_selfVy <= '0;
            r_sumX   <= '0;  r_sumY   <= '0;  r_sumVx  <= '0;  r_sumVy  <= '0;
            r_closeX <= '0;  r_closeY <= '0;
            r_outX   <= '0;  r_outY   <= '0;  r_outVx  <= '0;  r_outVy  <= '0;
            r_count  <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_divIdx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.self_valid) begin
                        r_selfX  <= bus.self_x;   r_selfY  <= bus.self_y;
                        r_selfVx <= bus.self_vx;  r_selfVy <= bus.self_vy;
                        r_sumX   <= '0;  r_sumY <= '0;  r_sumVx <= '0;  r_sumVy <= '0;
                        r_closeX <= '0;  r_closeY <= '0;
                        r_count  <= '0;
                        r_rem    <= '0;
                        r_quo    <= '0;
                        r_divIdx <= DIV_START;
                    end
                end
                S_ACCUM: begin
                    if (bus.nbr_valid) begin
                        if (w_dsq < PROT_WIDE) begin
                            r_closeX <= r_closeX + w_dx;
                            r_closeY <= r_closeY + w_dy;
                        end else if (w_dsq < VIS_WIDE && r_count < MAX_CNT) begin
                            r_sumX  <= r_sumX  + bus.nbr_x;
                            r_sumY  <= r_sumY  + bus.nbr_y;
                            r_sumVx <= r_sumVx + bus.nbr_vx;
                            r_sumVy <= r_sumVy + bus.nbr_vy;
                            r_count <= r_count + CW'(1);
                        end
                    end
                end
                S_DIV: begin
                    if (r_count != '0) begin
                        r_rem    <= w_remGe ? w_remSub[CW:0] : w_remShift[CW:0];
                        r_quo    <= {r_quo[W-2:0], w_remGe};
                        r_divIdx <= r_divIdx - IW'(1);
                    end
                end
                S_APPLY: begin
                    r_outX  <= r_selfX + w_vfX;
                    r_outY  <= r_selfY + w_vfY;
                    r_outVx <= w_vfX;
                    r_outVy <= w_vfY;
                end
                default: ;
            endcase
        end
    end

    assign bus.self_ready = w_selfReady;
    assign bus.nbr_ready  = w_nbrReady;
    assign bus.out_valid  = w_outValid;
    assign bus.out_x      = r_outX;
    assign bus.out_y      = r_outY;
    assign bus.out_vx     = r_outVx;
    assign bus.out_vy     = r_outVy;
    assign nbr_count      = r_count;
    assign busy           = (r_state != S_IDLE);

endmodule
